// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM state encoding and opcode constants.
package alu_seq_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_PASS = 3'b000;
  localparam op_t OP_INC  = 3'b001;
  localparam op_t OP_DEC  = 3'b010;
  localparam op_t OP_NOT  = 3'b011;
  localparam op_t OP_SHL  = 3'b100;
  localparam op_t OP_SHR  = 3'b101;
  localparam op_t OP_ROL  = 3'b110;
  localparam op_t OP_SWAP = 3'b111;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with a registered occupancy count; full/empty derive from that count only.
module cmd_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the opcode datapath: queues commands, drives one at a time, waits a fixed
// latency, then returns the captured result tagged with its opcode.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OPW     = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1,
  localparam int unsigned LW     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [OPW-1:0]   cmd_op,
  output logic [WIDTH-1:0] alu_in,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [OPW-1:0]   rsp_op,
  output logic             busy,
  output logic [LW-1:0]    level
);

  localparam int unsigned FW   = WIDTH + OPW;
  localparam int unsigned CntW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_in_q, alu_in_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [OPW-1:0]   rsp_op_q, rsp_op_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic [FW-1:0]    head;
  logic             fifo_full, fifo_empty, pop;

  cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data ({cmd_op, cmd_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign cmd_ready = !fifo_full;
  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign busy      = (state_q != IDLE);
  assign alu_in    = alu_in_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_in_d    = alu_in_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          alu_in_d = head[WIDTH-1:0];
          alu_op_d = head[FW-1:WIDTH];
          rsp_op_d = head[FW-1:WIDTH];
          cnt_d    = CntW'(LATENCY);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          rsp_data_d  = alu_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_in_q    <= '0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_in_q    <= alu_in_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a one-cycle registered datapath model.
module tb_alu_cmd_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned L  = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_data = '0;
  logic [OW-1:0] cmd_op = '0;
  logic [W-1:0]  alu_in;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_out = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic [OW-1:0] rsp_op;
  logic          busy;
  logic [2:0]    level;

  int tests = 0;
  int fails = 0;
  logic [OW+W-1:0] exp_q[$];
  bit rnd_rdy = 1'b0;

  alu_cmd_sequencer #(
    .WIDTH   (W),
    .OPW     (OW),
    .DEPTH   (D),
    .LATENCY (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_op    (cmd_op),
    .alu_in    (alu_in),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Behavioural opcode semantics, written as plain arithmetic.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [OW-1:0] o);
    int x;
    int r;
    x = int'(a);
    case (o)
      3'd0:    r = x;
      3'd1:    r = x + 1;
      3'd2:    r = x + 255;
      3'd3:    r = 255 - x;
      3'd4:    r = x * 2;
      3'd5:    r = x / 2;
      3'd6:    r = x * 2 + x / 128;
      default: r = (x % 16) * 16 + x / 16;
    endcase
    return W'(r % 256);
  endfunction

  always @(posedge clk) alu_out <= alu_fn(alu_in, alu_op);

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected response recorded when a command handshake is seen.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) exp_q.push_back({cmd_op, alu_fn(cmd_data, cmd_op)});
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {21'd0, rsp_op, rsp_data}, 32'hFFFF_FFFF);
      end else begin
        check("rsp_payload", {21'd0, rsp_op, rsp_data}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_cmd(input logic [W-1:0] d, input logic [OW-1:0] o);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_op    = o;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && level == 3'd0) break;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_level"},     {29'd0, level},     32'd0);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_alu_op"},    {29'd0, alu_op},    32'd0);
  endtask

  initial begin
    // Reset values before any clock edge.
    #2;
    check_reset("rst0");
    check("rst0_alu_in", {24'd0, alu_in}, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Single command, latency trace.
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_data  = 8'hA5;
    cmd_op    = 3'b101;
    @(posedge clk);  // E0
    #1;
    cmd_valid = 1'b0;
    check("single_level", {29'd0, level}, 32'd1);
    @(posedge clk);  // E1
    #1;
    check("single_alu_in", {24'd0, alu_in}, 32'hA5);
    check("single_alu_op", {29'd0, alu_op}, 32'd5);
    check("single_busy",   {31'd0, busy},   32'd1);
    @(posedge clk);  // E2
    #1;
    check("single_no_rsp_e2", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);  // E3
    #1;
    check("single_rsp_e3", {31'd0, rsp_valid}, 32'd1);
    check("single_rsp_val", {21'd0, rsp_op, rsp_data}, {21'd0, 3'b101, 8'h52});
    drain("single_drain");

    // Fill with responses blocked, then hold under backpressure.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_cmd(W'($urandom), OW'($urandom));
    check("fill_level",     {29'd0, level},     32'd4);
    check("fill_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1;
    cmd_data  = 8'h3C;
    cmd_op    = 3'b111;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_busy",      {31'd0, busy},      32'd1);
      check("bp_level",     {29'd0, level},     32'd4);
      if (exp_q.size() != 0) check("bp_payload", {21'd0, rsp_op, rsp_data}, {21'd0, exp_q[0]});
      else check("bp_queue", 32'd0, 32'd1);
    end
    rsp_ready = 1'b1;
    send_cmd(8'h3C, 3'b111);
    drain("fill_drain");

    // Opcode wrap with random data and random response stalls.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 12; i++) send_cmd(W'($urandom), OW'(i % 8));
    for (int i = 0; i < 16; i++) send_cmd(W'($urandom), OW'($urandom));
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    drain("wrap_drain");

    // Reset while WAIT with three queued commands.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(W'($urandom), OW'($urandom));
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 8'h77;
    cmd_op    = 3'b010;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("wait_level", {29'd0, level}, 32'd3);
    check("wait_busy",  {31'd0, busy},  32'd1);
    check("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset("rst1");
    exp_q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("rst1_hold_valid", {31'd0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_level", {29'd0, level}, 32'd0);
    send_cmd(8'h81, 3'b110);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
